ram2_master: RTL and testbench
==============================

Name: ram2_master

Overview:
- CPU-side initiator for the RAM2 SRAM-style port: ce/re/we, word address, 32-bit data in each direction.
- Takes one memory request at a time from the MEM stage and sequences the RAM2 strobes over configurable wait states.
- Byte-enable writes are done as read-modify-write; full-word writes go straight through.
- Drives a stall back to the pipeline until the access completes.

Parameters:
- ADDR_WIDTH, 12, RAM2 word-address width; mem_addr_o = cpu_addr_i[ADDR_WIDTH+1:2].
- READ_WAIT, 1, cycles ce/re held per RAM read (>=1).
- WRITE_WAIT, 1, cycles ce/we held per RAM write (>=1).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-low (0 = reset).
- cpu_req_i  in  1  request valid; held until cpu_ack_o.
- cpu_we_i  in  1  1 = write, 0 = read.
- cpu_addr_i  in  32  byte address; bits [1:0] ignored.
- cpu_sel_i  in  4  byte enables; bit n selects byte lane n (lane n = data[8n+7:8n]).
- cpu_data_i  in  32  write data.
- cpu_data_o  out  32  read data; valid while cpu_ack_o = 1.
- cpu_ack_o  out  1  one-cycle completion pulse.
- cpu_stall_o  out  1  pipeline stall.
- cpu_err_o  out  1  access fault; only used with the optional feature.
- mem_addr_o  out  ADDR_WIDTH  RAM2 word address.
- mem_data_o  out  32  RAM2 write data.
- mem_data_i  in  32  RAM2 read data; sampled on the last read cycle.
- mem_ce_o  out  1  chip enable.
- mem_re_o  out  1  read enable.
- mem_we_o  out  1  write enable.

Behaviour:
- Reset (rst = 0 at a clock edge):
  - state <- IDLE.
  - All registered outputs <- 0: cpu_data_o, cpu_ack_o, cpu_err_o, mem_addr_o, mem_data_o, mem_ce_o, mem_re_o, mem_we_o.
  - Wait counter <- 0.
  - An access in flight is abandoned. Its strobes drop at that same edge and no ack is issued.
- States: IDLE, RD, RMW_RD, WR, DONE.
- IDLE:
  - On cpu_req_i = 1, latch we/addr/sel/data, load the wait counter, and go to the next state:
    - read -> RD.
    - write, sel = 4'hF -> WR.
    - write, sel = 4'h0 -> DONE; no RAM access.
    - other write -> RMW_RD.
- RD:
  - ce = 1, re = 1, we = 0, mem_addr_o = latched word address.
  - Stays READ_WAIT cycles.
  - On the last cycle, capture mem_data_i into cpu_data_o, then go to DONE.
- RMW_RD:
  - Same strobes and length as RD.
  - On the last cycle, merge: lanes with sel = 1 take cpu_data, the other lanes take mem_data_i. Result goes to mem_data_o, then WR.
- WR:
  - ce = 1, we = 1, re = 0, mem_data_o stable.
  - Stays WRITE_WAIT cycles, then DONE.
- DONE:
  - cpu_ack_o = 1 for exactly one cycle; strobes 0; then IDLE.
  - cpu_req_i is ignored in DONE. The earliest next acceptance is the following IDLE cycle.
- Strobe rules:
  - re and we are never both 1.
  - ce = 0 whenever re = 0 and we = 0.
  - cpu_data_o is unchanged after a write access.
- cpu_stall_o is combinational:
  - 1 in RD, RMW_RD, WR.
  - 1 in IDLE when cpu_req_i = 1.
  - 0 in DONE and in an idle IDLE.
- Latency, counted from the accepting IDLE cycle to the ack cycle:
  - read: READ_WAIT + 1 cycles.
  - full-word write: WRITE_WAIT + 1 cycles.
  - partial write: READ_WAIT + WRITE_WAIT + 1 cycles.
  - sel = 0 write: 1 cycle.
- The address wraps modulo 2^ADDR_WIDTH words; upper bits are ignored unless the optional feature is enabled.
- Changes to cpu_* inputs after acceptance have no effect on the access in flight.

Optional Feature:
- Macro: RAM2_BOUND_CHECK_EN.
- Defined:
  - A request with any cpu_addr_i bit above ADDR_WIDTH+1 set goes IDLE -> DONE with no RAM strobes.
  - In that DONE cycle: cpu_err_o = 1, cpu_ack_o = 1, cpu_data_o = 0.
  - cpu_err_o is 0 in every other cycle.
- Not defined: cpu_err_o is tied to 0 and upper address bits are silently dropped.

Test Plan:
- Reset, then full write: rst low 2 cycles -> all outputs 0. Write addr 0x10, sel F, data 0xDEADBEEF -> mem_addr_o = 4, we = 1 for WRITE_WAIT cycles, ack 2 cycles after acceptance (WRITE_WAIT = 1).
- Read: read of addr 0x10, model returns 0xDEADBEEF -> ce/re high 1 cycle, cpu_data_o = 0xDEADBEEF with ack; stall high from the accept cycle until ack.
- Partial write: sel 4'b0010, data 0x0000AA00 over stored 0x11223344 -> RMW read, then write of 0x1122AA44; ack 3 cycles after acceptance.
- Wait states: READ_WAIT = 3, WRITE_WAIT = 2 -> read ack 4 cycles after acceptance, full write ack 3 cycles after acceptance; re/we never overlap; sel = 0 write acks in 1 cycle with no strobes.
- Reset mid-operation: rst low in the 2nd RD cycle with READ_WAIT = 3 -> strobes 0 at that edge, no ack; the next request completes normally.
- Bounds check: with RAM2_BOUND_CHECK_EN, read of addr 0x00004000 (ADDR_WIDTH = 12) -> no strobes, ack with err = 1 and data 0. Without the macro -> word 0 is accessed and err = 0.

Source files
------------

// File: rtl/ram2_master.sv
// ram2_master: single-outstanding CPU initiator for the RAM2 SRAM-style port.
// Optional address bound checking is enabled by defining RAM2_BOUND_CHECK_EN.
module ram2_master #(
  parameter int ADDR_WIDTH = 12,
  parameter int READ_WAIT  = 1,
  parameter int WRITE_WAIT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req_i,
  input  logic                  cpu_we_i,
  input  logic [31:0]           cpu_addr_i,
  input  logic [3:0]            cpu_sel_i,
  input  logic [31:0]           cpu_data_i,
  output logic [31:0]           cpu_data_o,
  output logic                  cpu_ack_o,
  output logic                  cpu_stall_o,
  output logic                  cpu_err_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [31:0]           mem_data_o,
  input  logic [31:0]           mem_data_i,
  output logic                  mem_ce_o,
  output logic                  mem_re_o,
  output logic                  mem_we_o
);

  typedef enum logic [2:0] {IDLE, RD, RMW_RD, WR, DONE} state_e;

  localparam int MAX_WAIT = (READ_WAIT > WRITE_WAIT) ? READ_WAIT : WRITE_WAIT;
  localparam int CNT_W    = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_WAIT - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WRITE_WAIT - 1);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [3:0]            sel_q, sel_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           rdata_q, rdata_d;
  logic [31:0]           mdata_q, mdata_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  ack_q, ack_d;
  logic                  err_q, err_d;
  logic                  ce_q, ce_d;
  logic                  re_q, re_d;
  logic                  we_q, we_d;
  logic                  bound_err_s;
  logic                  unused_addr_s;

`ifdef RAM2_BOUND_CHECK_EN
  assign bound_err_s   = |cpu_addr_i[31:ADDR_WIDTH+2];
  assign unused_addr_s = ^cpu_addr_i[1:0];
`else
  assign bound_err_s   = 1'b0;
  assign unused_addr_s = ^{cpu_addr_i[31:ADDR_WIDTH+2], cpu_addr_i[1:0]};
`endif

  // Byte lanes with sel set take the CPU data, the rest keep the stored word.
  function automatic logic [31:0] merge_lanes(input logic [3:0]  sel,
                                              input logic [31:0] wdata,
                                              input logic [31:0] rdata);
    logic [31:0] res;
    res = 32'h0;
    for (int n = 0; n < 4; n++) begin
      res[8*n +: 8] = sel[n] ? wdata[8*n +: 8] : rdata[8*n +: 8];
    end
    return res;
  endfunction

  // Next-state, latch and strobe logic; strobes are derived from the next state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    mdata_d = mdata_q;
    addr_d  = addr_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cpu_req_i) begin
          sel_d   = cpu_sel_i;
          wdata_d = cpu_data_i;
          addr_d  = cpu_addr_i[ADDR_WIDTH+1:2];
          cnt_d   = RD_LOAD;
          if (bound_err_s) begin
            state_d = DONE;
            err_d   = 1'b1;
            rdata_d = 32'h0;
          end else if (!cpu_we_i) begin
            state_d = RD;
          end else if (cpu_sel_i == 4'hF) begin
            state_d = WR;
            mdata_d = cpu_data_i;
            cnt_d   = WR_LOAD;
          end else if (cpu_sel_i == 4'h0) begin
            state_d = DONE;
          end else begin
            state_d = RMW_RD;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RD: begin
        if (cnt_q == '0) begin
          rdata_d = mem_data_i;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RMW_RD: begin
        if (cnt_q == '0) begin
          mdata_d = merge_lanes(sel_q, wdata_q, mem_data_i);
          cnt_d   = WR_LOAD;
          state_d = WR;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      WR: begin
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    re_d  = (state_d == RD) || (state_d == RMW_RD);
    we_d  = (state_d == WR);
    ce_d  = re_d || we_d;
    ack_d = (state_d == DONE);
  end

  // State and registered-output update with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sel_q   <= 4'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      mdata_q <= 32'h0;
      addr_q  <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      ce_q    <= 1'b0;
      re_q    <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      mdata_q <= mdata_d;
      addr_q  <= addr_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      ce_q    <= ce_d;
      re_q    <= re_d;
      we_q    <= we_d;
    end
  end

  assign cpu_stall_o = (state_q == RD) || (state_q == RMW_RD) || (state_q == WR) ||
                       ((state_q == IDLE) && cpu_req_i);
  assign cpu_data_o  = rdata_q;
  assign cpu_ack_o   = ack_q;
  assign cpu_err_o   = err_q;
  assign mem_addr_o  = addr_q;
  assign mem_data_o  = mdata_q;
  assign mem_ce_o    = ce_q;
  assign mem_re_o    = re_q;
  assign mem_we_o    = we_q;

endmodule

// File: tb/tb_ram2_master.sv
// Directed bench for ram2_master: one instance with 1/1 wait states, one with 3/2.
module tb_ram2_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_a, req_b, cpu_we;
  logic [31:0] cpu_addr, cpu_wd;
  logic [3:0]  cpu_sel;

  logic [31:0] rd_a, mdo_a, mdi_a, rd_b, mdo_b, mdi_b;
  logic        ack_a, stall_a, err_a, ce_a, re_a, we_a;
  logic        ack_b, stall_b, err_b, ce_b, re_b, we_b;
  logic [11:0] maddr_a, maddr_b;
  logic [31:0] mem_a [0:4095];
  logic [31:0] mem_b [0:4095];

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  ram2_master #(.ADDR_WIDTH(12), .READ_WAIT(1), .WRITE_WAIT(1)) dut (
    .clk(clk), .rst(rst), .cpu_req_i(req_a), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr),
    .cpu_sel_i(cpu_sel), .cpu_data_i(cpu_wd), .cpu_data_o(rd_a), .cpu_ack_o(ack_a),
    .cpu_stall_o(stall_a), .cpu_err_o(err_a), .mem_addr_o(maddr_a), .mem_data_o(mdo_a),
    .mem_data_i(mdi_a), .mem_ce_o(ce_a), .mem_re_o(re_a), .mem_we_o(we_a));

  ram2_master #(.ADDR_WIDTH(12), .READ_WAIT(3), .WRITE_WAIT(2)) dut_w (
    .clk(clk), .rst(rst), .cpu_req_i(req_b), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr),
    .cpu_sel_i(cpu_sel), .cpu_data_i(cpu_wd), .cpu_data_o(rd_b), .cpu_ack_o(ack_b),
    .cpu_stall_o(stall_b), .cpu_err_o(err_b), .mem_addr_o(maddr_b), .mem_data_o(mdo_b),
    .mem_data_i(mdi_b), .mem_ce_o(ce_b), .mem_re_o(re_b), .mem_we_o(we_b));

  assign mdi_a = (ce_a && re_a) ? mem_a[maddr_a] : 32'h0;
  assign mdi_b = (ce_b && re_b) ? mem_b[maddr_b] : 32'h0;

  always @(posedge clk) begin
    if (ce_a && we_a) mem_a[maddr_a] <= mdo_a;
    if (ce_b && we_b) mem_b[maddr_b] <= mdo_b;
  end

  // Runs one access; flags protocol violations in bad, returns latency (-1 on timeout).
  task automatic access(input bit b, input bit we, input logic [31:0] addr,
                        input logic [3:0] sel, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd, output logic err,
                        output int re_n, output int we_n, output bit bad,
                        output logic [11:0] last_addr);
    logic ack, ce, re, wes, st;
    cpu_we = we; cpu_addr = addr; cpu_sel = sel; cpu_wd = wd;
    if (b) req_b = 1'b1; else req_a = 1'b1;
    lat = 0; re_n = 0; we_n = 0; bad = 1'b0; rd = 32'h0; err = 1'b0;
    last_addr = 12'h0; ack = 1'b0;
    #1;
    st = b ? stall_b : stall_a;
    if (!st) bad = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) begin
        cpu_addr = 32'h0000_3FFC; cpu_wd = ~wd; cpu_sel = ~sel; cpu_we = ~we;
      end
      ack = b ? ack_b : ack_a;
      ce  = b ? ce_b : ce_a;
      re  = b ? re_b : re_a;
      wes = b ? we_b : we_a;
      st  = b ? stall_b : stall_a;
      if (ack) begin
        rd  = b ? rd_b : rd_a;
        err = b ? err_b : err_a;
        if (ce || re || wes || st) bad = 1'b1;
        break;
      end
      if (re) re_n++;
      if (wes) we_n++;
      if (re && wes) bad = 1'b1;
      if (ce != (re || wes)) bad = 1'b1;
      if (!st) bad = 1'b1;
      if (re || wes) last_addr = b ? maddr_b : maddr_a;
    end
    if (!ack) lat = -1;
    req_a = 1'b0; req_b = 1'b0;
    @(posedge clk); #1;
    if (b ? ack_b : ack_a) bad = 1'b1;
    if (b ? err_b : err_a) bad = 1'b1;
  endtask

  int          lat, re_n, we_n;
  logic [31:0] rd;
  logic        err;
  bit          bad;
  logic [11:0] la;

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({rd_a, ack_a, err_a, maddr_a, mdo_a, ce_a, re_a, we_a, stall_a} !== 80'h0)
      $display("FAIL reset_a: got %h expected 0", {rd_a, ack_a, err_a, maddr_a, mdo_a, ce_a, re_a, we_a, stall_a});
    else passes++;
    checks++;
    if ({rd_b, ack_b, err_b, maddr_b, mdo_b, ce_b, re_b, we_b, stall_b} !== 80'h0)
      $display("FAIL reset_b: got %h expected 0", {rd_b, ack_b, err_b, maddr_b, mdo_b, ce_b, re_b, we_b, stall_b});
    else passes++;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_full_write();
    access(1'b0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, lat, rd, err, re_n, we_n, bad, la);
    checks++; if (lat !== 2) $display("FAIL fw_latency: got %0d expected 2", lat); else passes++;
    checks++; if (we_n !== 1 || re_n !== 0) $display("FAIL fw_strobes: got we=%0d re=%0d expected we=1 re=0", we_n, re_n); else passes++;
    checks++; if (la !== 12'h4) $display("FAIL fw_addr: got %h expected 004", la); else passes++;
    checks++; if (mem_a[4] !== 32'hDEADBEEF) $display("FAIL fw_mem: got %h expected deadbeef", mem_a[4]); else passes++;
    checks++; if (rd !== 32'h0) $display("FAIL fw_rdata_kept: got %h expected 0", rd); else passes++;
    checks++; if (bad) $display("FAIL fw_protocol: got 1 expected 0"); else passes++;
  endtask

  task automatic test_read();
    access(1'b0, 1'b0, 32'h10, 4'hF, 32'h0, lat, rd, err, re_n, we_n, bad, la);
    checks++; if (lat !== 2) $display("FAIL rd_latency: got %0d expected 2", lat); else passes++;
    checks++; if (re_n !== 1 || we_n !== 0) $display("FAIL rd_strobes: got re=%0d we=%0d expected re=1 we=0", re_n, we_n); else passes++;
    checks++; if (rd !== 32'hDEADBEEF || err !== 1'b0) $display("FAIL rd_data: got %h err=%b expected deadbeef err=0", rd, err); else passes++;
    checks++; if (bad) $display("FAIL rd_protocol: got 1 expected 0"); else passes++;
  endtask

  task automatic test_partial_write();
    mem_a[5] = 32'h11223344;
    access(1'b0, 1'b1, 32'h14, 4'b0010, 32'h0000AA00, lat, rd, err, re_n, we_n, bad, la);
    checks++; if (lat !== 3) $display("FAIL pw_latency: got %0d expected 3", lat); else passes++;
    checks++; if (re_n !== 1 || we_n !== 1) $display("FAIL pw_strobes: got re=%0d we=%0d expected 1 1", re_n, we_n); else passes++;
    checks++; if (mem_a[5] !== 32'h1122AA44) $display("FAIL pw_merge: got %h expected 1122aa44", mem_a[5]); else passes++;
    checks++; if (rd !== 32'hDEADBEEF) $display("FAIL pw_rdata_kept: got %h expected deadbeef", rd); else passes++;
    checks++; if (bad) $display("FAIL pw_protocol: got 1 expected 0"); else passes++;
  endtask

  task automatic test_wait_states();
    access(1'b1, 1'b1, 32'h20, 4'hF, 32'hCAFEF00D, lat, rd, err, re_n, we_n, bad, la);
    checks++; if (lat !== 3 || we_n !== 2) $display("FAIL ws_fw: got lat=%0d we=%0d expected 3 2", lat, we_n); else passes++;
    checks++; if (mem_b[8] !== 32'hCAFEF00D || bad) $display("FAIL ws_fw_mem: got %h bad=%b expected cafef00d bad=0", mem_b[8], bad); else passes++;
    access(1'b1, 1'b0, 32'h20, 4'hF, 32'h0, lat, rd, err, re_n, we_n, bad, la);
    checks++; if (lat !== 4 || re_n !== 3) $display("FAIL ws_rd: got lat=%0d re=%0d expected 4 3", lat, re_n); else passes++;
    checks++; if (rd !== 32'hCAFEF00D || bad) $display("FAIL ws_rd_data: got %h bad=%b expected cafef00d bad=0", rd, bad); else passes++;
    mem_b[9] = 32'h11223344;
    access(1'b1, 1'b1, 32'h24, 4'b1000, 32'hAB000000, lat, rd, err, re_n, we_n, bad, la);
    checks++; if (lat !== 6 || re_n !== 3 || we_n !== 2) $display("FAIL ws_pw: got lat=%0d re=%0d we=%0d expected 6 3 2", lat, re_n, we_n); else passes++;
    checks++; if (mem_b[9] !== 32'hAB223344 || bad) $display("FAIL ws_pw_mem: got %h bad=%b expected ab223344 bad=0", mem_b[9], bad); else passes++;
    access(1'b1, 1'b1, 32'h24, 4'h0, 32'hFFFFFFFF, lat, rd, err, re_n, we_n, bad, la);
    checks++; if (lat !== 1 || re_n !== 0 || we_n !== 0) $display("FAIL ws_sel0: got lat=%0d re=%0d we=%0d expected 1 0 0", lat, re_n, we_n); else passes++;
    checks++; if (mem_b[9] !== 32'hAB223344 || bad) $display("FAIL ws_sel0_mem: got %h bad=%b expected ab223344 bad=0", mem_b[9], bad); else passes++;
  endtask

  task automatic test_mid_reset();
    bit saw_ack;
    cpu_we = 1'b0; cpu_addr = 32'h20; cpu_sel = 4'hF; cpu_wd = 32'h0;
    req_b = 1'b1;
    @(posedge clk); #1;
    checks++; if (!(ce_b && re_b)) $display("FAIL mr_rd1: got ce=%b re=%b expected 1 1", ce_b, re_b); else passes++;
    @(posedge clk); #1;
    rst = 1'b0; req_b = 1'b0;
    @(posedge clk); #1;
    checks++; if ({ce_b, re_b, we_b, ack_b} !== 4'b0) $display("FAIL mr_abort: got %b expected 0000", {ce_b, re_b, we_b, ack_b}); else passes++;
    rst = 1'b1;
    saw_ack = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if (ack_b || ce_b) saw_ack = 1'b1;
    end
    checks++; if (saw_ack) $display("FAIL mr_no_ack: got 1 expected 0"); else passes++;
    access(1'b1, 1'b0, 32'h20, 4'hF, 32'h0, lat, rd, err, re_n, we_n, bad, la);
    checks++; if (lat !== 4 || rd !== 32'hCAFEF00D || bad) $display("FAIL mr_recover: got lat=%0d data=%h bad=%b expected 4 cafef00d 0", lat, rd, bad); else passes++;
  endtask

  task automatic test_bounds();
    mem_a[0] = 32'h5A5A1234;
    access(1'b0, 1'b0, 32'h00004000, 4'hF, 32'h0, lat, rd, err, re_n, we_n, bad, la);
`ifdef RAM2_BOUND_CHECK_EN
    checks++; if (lat !== 1 || re_n !== 0 || we_n !== 0) $display("FAIL bc_path: got lat=%0d re=%0d we=%0d expected 1 0 0", lat, re_n, we_n); else passes++;
    checks++; if (err !== 1'b1 || rd !== 32'h0) $display("FAIL bc_err: got err=%b data=%h expected 1 0", err, rd); else passes++;
`else
    checks++; if (lat !== 2 || re_n !== 1 || la !== 12'h0) $display("FAIL bc_wrap: got lat=%0d re=%0d addr=%h expected 2 1 000", lat, re_n, la); else passes++;
    checks++; if (err !== 1'b0 || rd !== 32'h5A5A1234) $display("FAIL bc_data: got err=%b data=%h expected 0 5a5a1234", err, rd); else passes++;
`endif
    checks++; if (bad) $display("FAIL bc_protocol: got 1 expected 0"); else passes++;
  endtask

  initial begin
    req_a = 1'b0; req_b = 1'b0; cpu_we = 1'b0;
    cpu_addr = 32'h0; cpu_sel = 4'h0; cpu_wd = 32'h0;
    test_reset();
    test_full_write();
    test_read();
    test_partial_write();
    test_wait_states();
    test_mid_reset();
    test_bounds();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
